// File: rtl/tm1638_frame_ctrl_if.sv
// Byte-engine handshake bundle between the TM1638 frame sequencer and the serial engine.
// Latency: none, wires only.
// Backpressure: the engine holds off new bytes by keeping eng_busy high.
interface tm1638_frame_ctrl_if;
    logic       eng_step;
    logic [7:0] eng_data;
    logic       eng_rw;
    logic       eng_busy;
    logic [7:0] eng_rdata;

    modport master (
        output eng_step, eng_data, eng_rw,
        input  eng_busy, eng_rdata
    );

    modport slave (
        input  eng_step, eng_data, eng_rw,
        output eng_busy, eng_rdata
    );
endinterface

// File: rtl/tm1638_frame_ctrl.sv
// TM1638 frame sequencer: snapshots display inputs and runs four STB-framed transactions.
// Latency: one full frame (24 engine bytes plus STB gaps) from start to keys_valid.
// Backpressure: each byte waits for eng_busy low; start is dropped while a frame is running.
module tm1638_frame_ctrl #(
    parameter int STB_GAP   = 4,
    parameter int READ_WAIT = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [63:0]                digits,
    input  logic [7:0]                 leds,
    input  logic [2:0]                 brightness,
    input  logic                       display_on,
    output logic                       busy,
    output logic [31:0]                keys,
    output logic                       keys_valid,
    output logic                       stb,
    output logic                       dio_oe,
    tm1638_frame_ctrl_if.master        eng
);

    localparam int GAP_MAX = (STB_GAP > READ_WAIT) ? STB_GAP : READ_WAIT;
    localparam int GW      = $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(STB_GAP - 1);
    localparam logic [GW-1:0] RD_LAST  = GW'(READ_WAIT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_GAP_PRE, S_STB_LO, S_ISSUE, S_WAIT_HI,
        S_WAIT_LO, S_RD_WAIT, S_STB_END, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       gap_cnt;
    logic [4:0]          byte_cnt;
    logic [1:0]          txn;
    logic [4:0]          last_idx;
    logic [7:0][7:0]     snap_digits;
    logic [7:0]          snap_leds;
    logic [2:0]          snap_bright;
    logic                snap_on;
    logic [3:0][7:0]     key_buf;
    logic [3:0]          burst_idx;
    logic [1:0]          key_idx;
    logic [7:0]          cur_byte;
    logic                rd_phase;

    // T3 bytes after the 0x42 command are key-scan reads
    assign rd_phase = (txn == 2'd3) && (byte_cnt != 5'd0);
    assign last_idx = (txn == 2'd1) ? 5'd16 : (txn == 2'd3) ? 5'd4 : 5'd0;
    assign key_idx  = byte_cnt[1:0] - 2'd1;

    // State register; reset drops straight to IDLE so stb rises on the same edge
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: STB framing, per-byte engine handshake and read turnaround
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_GAP_PRE;
            S_GAP_PRE: if (gap_cnt == GAP_LAST) state_nxt = S_STB_LO;
            S_STB_LO:  if (gap_cnt == GAP_LAST) state_nxt = S_ISSUE;
            S_ISSUE:   if (!eng.eng_busy) state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (eng.eng_busy) state_nxt = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!eng.eng_busy) begin
                    if (txn == 2'd3 && byte_cnt == 5'd0) state_nxt = S_RD_WAIT;
                    else if (byte_cnt != last_idx)       state_nxt = S_ISSUE;
                    else                                 state_nxt = S_STB_END;
                end
            end
            S_RD_WAIT: if (gap_cnt == RD_LAST) state_nxt = S_ISSUE;
            S_STB_END: if (gap_cnt == GAP_LAST) state_nxt = (txn == 2'd3) ? S_DONE : S_GAP_PRE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; step is gated by engine idle so it lasts one cycle
    always_comb begin
        busy         = (state != S_IDLE);
        stb          = !(state inside {S_STB_LO, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_RD_WAIT, S_STB_END});
        dio_oe       = !(rd_phase && (state inside {S_RD_WAIT, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_STB_END}));
        eng.eng_step = (state == S_ISSUE) && !eng.eng_busy;
        eng.eng_data = (state == S_ISSUE) ? cur_byte : 8'h00;
        eng.eng_rw   = (state == S_ISSUE) ? !rd_phase : 1'b1;
    end

    // Byte to send for the current transaction/byte position
    always_comb begin
        burst_idx = byte_cnt[3:0] - 4'd1;
        cur_byte  = 8'h00;
        case (txn)
            2'd0: cur_byte = 8'h40;
            2'd1: begin
                if (byte_cnt == 5'd0)  cur_byte = 8'hC0;
                else if (burst_idx[0]) cur_byte = {7'b0, snap_leds[burst_idx[3:1]]};
                else                   cur_byte = snap_digits[burst_idx[3:1]];
            end
            2'd2: cur_byte = snap_on ? {5'b10001, snap_bright} : 8'h80;
            default: cur_byte = (byte_cnt == 5'd0) ? 8'h42 : 8'h00;
        endcase
    end

    // Counters, input snapshot, key capture and the keys_valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt     <= '0;
            byte_cnt    <= '0;
            txn         <= '0;
            snap_digits <= '0;
            snap_leds   <= '0;
            snap_bright <= '0;
            snap_on     <= 1'b0;
            key_buf     <= '0;
            keys        <= '0;
            keys_valid  <= 1'b0;
        end else begin
            keys_valid <= 1'b0;
            gap_cnt    <= (state_nxt != state) ? '0 : gap_cnt + 1'b1;
            if (state == S_IDLE && start) begin
                snap_digits <= digits;
                snap_leds   <= leds;
                snap_bright <= brightness;
                snap_on     <= display_on;
                txn         <= '0;
                byte_cnt    <= '0;
            end
            if (state == S_WAIT_LO && !eng.eng_busy) begin
                if (rd_phase) key_buf[key_idx] <= eng.eng_rdata;
                byte_cnt <= byte_cnt + 5'd1;
            end
            if (state == S_STB_END && state_nxt != S_STB_END) begin
                byte_cnt <= '0;
                txn      <= txn + 2'd1;
                if (txn == 2'd3) begin
                    keys       <= key_buf;
                    keys_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tm1638_frame_ctrl.sv
// Bench for tm1638_frame_ctrl: directed frames, engine model, queue scoreboard.
// Latency: checks each engine byte as it is stepped and keys when keys_valid pulses.
// Backpressure: engine model holds eng_busy for a few cycles (200 on one byte in the stall case).
module tb_tm1638_frame_ctrl;
    localparam int STB_GAP   = 4;
    localparam int READ_WAIT = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] digits = '0;
    logic [7:0]  leds = '0;
    logic [2:0]  brightness = '0;
    logic        display_on = 1'b0;
    logic        busy;
    logic [31:0] keys;
    logic        keys_valid;
    logic        stb;
    logic        dio_oe;

    tm1638_frame_ctrl_if eng_if ();

    tm1638_frame_ctrl #(.STB_GAP(STB_GAP), .READ_WAIT(READ_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .digits     (digits),
        .leds       (leds),
        .brightness (brightness),
        .display_on (display_on),
        .busy       (busy),
        .keys       (keys),
        .keys_valid (keys_valid),
        .stb        (stb),
        .dio_oe     (dio_oe),
        .eng        (eng_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_dat[$];
    logic        exp_rw[$];
    logic [31:0] exp_keys[$];

    int          frame_steps = 0;
    int          stb_falls = 0;
    int          dio_low = 0;
    int          frames_done = 0;
    int          eng_n = 0;
    int          rd_idx = 0;
    logic        long_mode = 1'b0;
    logic [7:0]  rd_vals[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push_byte(input logic [7:0] d, input logic rw);
        exp_dat.push_back(d);
        exp_rw.push_back(rw);
    endfunction

    // Expected engine byte stream and key result for one frame
    function automatic void push_frame(input logic [63:0] d, input logic [7:0] l,
                                       input logic [2:0] b, input logic on);
        push_byte(8'h40, 1'b1);
        push_byte(8'hC0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            push_byte(d[8*i +: 8], 1'b1);
            push_byte({7'b0, l[i]}, 1'b1);
        end
        push_byte(on ? (8'h88 | {5'b0, b}) : 8'h80, 1'b1);
        push_byte(8'h42, 1'b1);
        for (int i = 0; i < 4; i++) push_byte(8'h00, 1'b0);
        exp_keys.push_back({rd_vals[3], rd_vals[2], rd_vals[1], rd_vals[0]});
    endfunction

    task automatic do_start(input logic [63:0] d, input logic [7:0] l,
                            input logic [2:0] b, input logic on);
        @(negedge clk);
        digits = d; leds = l; brightness = b; display_on = on;
        eng_n = 0; rd_idx = 0;
        push_frame(d, l, b, on);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_frame(input bit drop_in_done);
        int n = 0;
        while (!keys_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!keys_valid) begin
            checks++; errors++;
            $display("FAIL frame_timeout actual=no_keys_valid required=keys_valid");
        end else if (drop_in_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Engine model: busy one cycle after a step, held for a few cycles, read data on release
    initial begin
        logic is_rd;
        int   hold;
        logic stb_bad;
        eng_if.eng_busy  = 1'b0;
        eng_if.eng_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_if.eng_step) begin
                is_rd = !eng_if.eng_rw;
                hold  = (long_mode && eng_n == 5) ? 200 : 3;
                eng_n++;
                @(negedge clk);
                eng_if.eng_busy = 1'b1;
                stb_bad = 1'b0;
                repeat (hold - 1) begin
                    @(negedge clk);
                    if (stb) stb_bad = 1'b1;
                end
                if (hold == 200) chk("stb_low_during_stall", stb_bad, 0);
                if (is_rd) begin
                    eng_if.eng_rdata = rd_vals[rd_idx % 4];
                    rd_idx++;
                end
                eng_if.eng_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every engine step and on keys_valid
    initial begin
        logic prev_stb;
        logic kv_prev;
        prev_stb = 1'b1;
        kv_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_dat.delete(); exp_rw.delete(); exp_keys.delete();
                frame_steps = 0; stb_falls = 0; dio_low = 0;
                prev_stb = 1'b1; kv_prev = 1'b0;
            end else begin
                if (prev_stb && !stb) stb_falls++;
                prev_stb = stb;
                dio_low  = dio_oe ? 0 : dio_low + 1;
                if (kv_prev) chk("busy_after_keys_valid", busy, 0);
                if (eng_if.eng_step) begin
                    frame_steps++;
                    chk("step_stb_low", stb, 0);
                    chk("step_engine_idle", eng_if.eng_busy, 0);
                    if (exp_dat.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_step actual=%0h required=none", eng_if.eng_data);
                    end else begin
                        chk("step_data", eng_if.eng_data, exp_dat.pop_front());
                        chk("step_rw", eng_if.eng_rw, exp_rw.pop_front());
                    end
                    if (!eng_if.eng_rw) begin
                        chk("read_dio_released", dio_oe, 0);
                        chk("read_turnaround", dio_low >= READ_WAIT, 1);
                    end
                end
                if (keys_valid) begin
                    frames_done++;
                    if (exp_keys.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_keys_valid actual=%0h required=none", keys);
                    end else begin
                        chk("keys", keys, exp_keys.pop_front());
                    end
                    chk("frame_steps", frame_steps, 24);
                    chk("frame_stb_falls", stb_falls, 4);
                    chk("done_stb_high", stb, 1);
                    chk("done_dio_oe", dio_oe, 1);
                    frame_steps = 0;
                    stb_falls   = 0;
                end
                kv_prev = keys_valid;
            end
        end
    end

    // Directed frames
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_keys", keys, 0);
        chk("rst_keys_valid", keys_valid, 0);
        chk("rst_stb", stb, 1);
        chk("rst_dio_oe", dio_oe, 1);
        chk("rst_eng_step", eng_if.eng_step, 0);
        chk("rst_eng_data", eng_if.eng_data, 0);
        chk("rst_eng_rw", eng_if.eng_rw, 1);
        @(negedge clk);
        rst = 1'b0;

        // Frame A: reference pattern, plus a start in the DONE cycle that must be dropped
        rd_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_start(64'h0706050403020100, 8'h81, 3'd5, 1'b1);
        wait_frame(1'b1);
        repeat (30) @(negedge clk);
        chk("done_start_dropped", busy, 0);
        chk("frame_a_keys", keys, 32'h44332211);

        // Frame B: display off, inputs scrambled after start, second start mid-frame
        rd_vals = '{8'h5A, 8'hA5, 8'h00, 8'hFF};
        do_start(64'h8899AABBCCDDEEFF, 8'h5A, 3'd7, 1'b0);
        digits = '1; leds = '1; brightness = 3'd0; display_on = 1'b1;
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_frame(1'b0);

        // Frame C: engine stalls 200 cycles on byte 5
        long_mode = 1'b1;
        rd_vals = '{8'h01, 8'h02, 8'h04, 8'h08};
        do_start(64'h3F065B4F666D7D07, 8'h0F, 3'd0, 1'b1);
        wait_frame(1'b0);
        long_mode = 1'b0;

        // Frame D: reset during T1 byte 7
        rd_vals = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_start(64'h0123456789ABCDEF, 8'hF0, 3'd2, 1'b1);
        n = 0;
        while (frame_steps < 9 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (frame_steps < 9) begin
            checks++; errors++;
            $display("FAIL reach_t1_byte7 actual=%0d required=9", frame_steps);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_stb", stb, 1);
        chk("abort_dio_oe", dio_oe, 1);
        chk("abort_busy", busy, 0);
        chk("abort_keys", keys, 0);
        chk("abort_keys_valid", keys_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Frame E: full frame after the abort
        rd_vals = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_start(64'hC0F9A4B0999282F8, 8'h3C, 3'd6, 1'b1);
        wait_frame(1'b0);
        repeat (5) @(negedge clk);
        chk("frames_done", frames_done, 4);
        chk("final_keys", keys, 32'h78563412);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
